fx2_fifo_rx: RTL and testbench

- Upstream receive stage for the FPGA top: drains bytes from the FX2 synchronous slave FIFO (host-to-FPGA endpoint) over the 8-bit data bus.
- Controls the FX2 SLOE/SLRD strobes and buffers received bytes in a local FWFT FIFO.
- Presents the bytes to downstream logic as a valid/ready byte stream.
- Runs entirely on the FX2 interface clock.

---
 rtl/fx2_fifo_rx.sv | 190 +++++++++++++++++++
 tb/tb_fx2_fifo_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_fifo_rx.sv
// fx2_fifo_rx: receive stage that drains the FX2 slave FIFO (host-to-FPGA
// endpoint). It drives SLOE/SLRD and buffers the received bytes in a local
// first-word-fall-through FIFO. Downstream logic reads them as a valid/ready
// byte stream. All logic runs on the rising edge of the FX2 interface clock.
module fx2_fifo_rx #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned IDLE_TIMEOUT = 8,
  parameter logic [1:0]  FIFOADR      = 2'b00
) (
  input  logic        USB_CLKO,
  input  logic        USB_RESET2,
  input  logic        fx2_empty_n,
  input  logic [7:0]  fx2_data,
  output logic        fx2_sloe_n,
  output logic        fx2_slrd_n,
  output logic [1:0]  fx2_fifoadr,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] rx_count,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam logic [OW-1:0] OCC_FULL    = OW'(DEPTH);
  // Strobing stops above this level so that the byte already on its way
  // through the registered SLRD path still has a slot.
  localparam logic [OW-1:0] OCC_THR     = OW'(DEPTH - 2);
  localparam logic [7:0]    TIMEOUT_VAL = 8'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    READ = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic           sloe_n_r;
  logic           sloe_n_next_s;
  logic           slrd_n_r;
  logic           slrd_n_next_s;
  logic [7:0]     idle_cnt_r;
  logic [7:0]     idle_cnt_next_s;

  logic [7:0]     mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [OW-1:0]  occ_r;
  logic [OW-1:0]  occ_next_s;
  logic [15:0]    rx_count_r;
  logic           overflow_r;

  logic           capture_s;
  logic           pop_s;
  logic           push_s;
  logic           drop_s;
  logic           full_s;
  logic           valid_s;
  logic           room_now_s;
  logic           room_next_s;
  logic           strobe_ok_s;
  logic [7:0]     idle_inc_s;

  // A capture happens whenever the strobe that is on the bus meets a
  // non-empty endpoint; a full buffer without a simultaneous pop drops it.
  assign capture_s   = ~slrd_n_r & fx2_empty_n;
  assign valid_s     = (occ_r != {OW{1'b0}});
  assign full_s      = (occ_r == OCC_FULL);
  assign pop_s       = valid_s & out_ready;
  assign push_s      = capture_s & (~full_s | pop_s);
  assign drop_s      = capture_s & full_s & ~pop_s;
  assign room_now_s  = (occ_r <= OCC_THR);
  assign room_next_s = (occ_next_s <= OCC_THR);
  assign strobe_ok_s = fx2_empty_n & room_next_s;
  assign idle_inc_s  = idle_cnt_r + 8'd1;

  // Occupancy after this edge's push/pop.
  always_comb begin
    occ_next_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_next_s = occ_r + OW'(1);
      2'b01:   occ_next_s = occ_r - OW'(1);
      default: occ_next_s = occ_r;
    endcase
  end

  // Next-state, strobe and idle-counter decode for the read sequencer.
  always_comb begin
    state_next_s    = state_r;
    sloe_n_next_s   = 1'b1;
    slrd_n_next_s   = 1'b1;
    idle_cnt_next_s = 8'd0;
    case (state_r)
      IDLE: begin
        if (fx2_empty_n && room_now_s) begin
          state_next_s  = TURN;
          sloe_n_next_s = 1'b0;
        end else begin
          state_next_s  = IDLE;
        end
      end
      TURN: begin
        // Bus has been turned around; first strobe goes out on this edge.
        state_next_s  = READ;
        sloe_n_next_s = 1'b0;
        slrd_n_next_s = ~strobe_ok_s;
      end
      READ: begin
        if (capture_s) begin
          idle_cnt_next_s = 8'd0;
        end else begin
          idle_cnt_next_s = idle_inc_s;
        end
        if (!capture_s && (idle_inc_s == TIMEOUT_VAL)) begin
          // Release the bus after a run of cycles without data.
          state_next_s    = IDLE;
          sloe_n_next_s   = 1'b1;
          slrd_n_next_s   = 1'b1;
          idle_cnt_next_s = 8'd0;
        end else begin
          state_next_s  = READ;
          sloe_n_next_s = 1'b0;
          slrd_n_next_s = ~strobe_ok_s;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Sequencer state, registered FX2 strobes and idle counter.
  always_ff @(posedge USB_CLKO) begin
    if (USB_RESET2) begin
      state_r    <= IDLE;
      sloe_n_r   <= 1'b1;
      slrd_n_r   <= 1'b1;
      idle_cnt_r <= 8'd0;
    end else begin
      state_r    <= state_next_s;
      sloe_n_r   <= sloe_n_next_s;
      slrd_n_r   <= slrd_n_next_s;
      idle_cnt_r <= idle_cnt_next_s;
    end
  end

  // Buffer storage; stale contents are never visible because out_data is
  // gated by occupancy.
  always_ff @(posedge USB_CLKO) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= fx2_data;
    end
  end

  // Buffer pointers, occupancy, capture counter and sticky overflow flag.
  always_ff @(posedge USB_CLKO) begin
    if (USB_RESET2) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      occ_r      <= {OW{1'b0}};
      rx_count_r <= 16'd0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      occ_r <= occ_next_s;
      if (capture_s) begin
        rx_count_r <= rx_count_r + 16'd1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign fx2_sloe_n  = sloe_n_r;
  assign fx2_slrd_n  = slrd_n_r;
  assign fx2_fifoadr = FIFOADR;
  assign out_valid   = valid_s;
  assign out_data    = valid_s ? mem_r[rd_ptr_r] : 8'h00;
  assign rx_count    = rx_count_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_fx2_fifo_rx.sv
// Bench for fx2_fifo_rx: an FX2 endpoint model feeds bytes, a reference
// queue models the local buffer, and a monitor compares what the design
// presents downstream against that queue.
module tb_fx2_fifo_rx;

  localparam int DEPTH        = 16;
  localparam int IDLE_TIMEOUT = 8;

  logic        USB_CLKO = 1'b0;
  logic        USB_RESET2 = 1'b1;
  logic        fx2_empty_n = 1'b0;
  logic [7:0]  fx2_data = 8'h00;
  logic        fx2_sloe_n;
  logic        fx2_slrd_n;
  logic [1:0]  fx2_fifoadr;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] rx_count;
  logic        overflow;

  fx2_fifo_rx #(.DEPTH(DEPTH), .IDLE_TIMEOUT(IDLE_TIMEOUT), .FIFOADR(2'b00)) dut (
    .USB_CLKO    (USB_CLKO),
    .USB_RESET2  (USB_RESET2),
    .fx2_empty_n (fx2_empty_n),
    .fx2_data    (fx2_data),
    .fx2_sloe_n  (fx2_sloe_n),
    .fx2_slrd_n  (fx2_slrd_n),
    .fx2_fifoadr (fx2_fifoadr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rx_count    (rx_count),
    .overflow    (overflow)
  );

  always #5 USB_CLKO = ~USB_CLKO;

  int checks = 0;
  int errors = 0;

  logic [7:0] fx2_q[$];   // bytes the FX2 endpoint still holds
  logic [7:0] exp_q[$];   // bytes the local buffer should hold, in order
  int  exp_count = 0;
  bit  exp_ovf = 1'b0;
  int  delivered = 0;
  int  cyc = 0;
  int  first_cap_cyc = 0;
  int  occ_max = 0;
  bit  fx2_gaps = 1'b0;
  bit  mon_en = 1'b0;

  // Bus values in effect at the upcoming rising edge.
  logic       s_slrd = 1'b1;
  logic       s_empty = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_rst = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // FX2 endpoint model and buffer reference model.
  always begin
    @(negedge USB_CLKO);
    cyc++;
    if (s_rst) begin
      if (!s_slrd && s_empty) void'(fx2_q.pop_front());
      exp_q.delete();
      exp_count = 0;
      exp_ovf = 1'b0;
    end else if (!s_slrd && s_empty) begin
      void'(fx2_q.pop_front());
      exp_count++;
      if (exp_count == 1) first_cap_cyc = cyc;
      if (exp_q.size() < DEPTH) exp_q.push_back(s_data);
      else exp_ovf = 1'b1;
    end
    if (exp_q.size() > occ_max) occ_max = exp_q.size();
    fx2_empty_n = (fx2_q.size() != 0) && !(fx2_gaps && ($urandom_range(0, 3) == 0));
    fx2_data = fx2_empty_n ? fx2_q[0] : 8'($urandom);
    #2;
    s_slrd  = fx2_slrd_n;
    s_empty = fx2_empty_n;
    s_data  = fx2_data;
    s_rst   = USB_RESET2;
  end

  // Downstream monitor: compares the presented stream with the reference.
  always begin
    @(negedge USB_CLKO);
    #2;
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("rx_count", 32'(rx_count), 32'(exp_count % 65536));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(exp_q[0]));
        if (out_ready && !USB_RESET2) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
    end
  end

  task automatic step();
    @(negedge USB_CLKO);
    #1;
  endtask

  task automatic do_reset();
    USB_RESET2 = 1'b1;
    step();
    step();
    USB_RESET2 = 1'b0;
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n;
    n = 0;
    while ((fx2_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(fx2_q.size() + exp_q.size()), 32'd0);
  endtask

  int rise_cyc;
  int n;

  initial begin
    step(); step(); step();
    USB_RESET2 = 1'b0;
    mon_en = 1'b1;
    chk("reset_out_data", 32'(out_data), 32'h00);
    chk("fifoadr", 32'(fx2_fifoadr), 32'd0);

    // Idle with no data on the endpoint.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_sloe", 32'(fx2_sloe_n), 32'd1);
      chk("idle_slrd", 32'(fx2_slrd_n), 32'd1);
      chk("idle_valid", 32'(out_valid), 32'd0);
      chk("idle_rxcnt", 32'(rx_count), 32'd0);
    end

    // Five-byte burst, latency and bus release after the idle timeout.
    out_ready = 1'b1;
    delivered = 0;
    for (int b = 8'h11; b <= 8'h15; b++) fx2_q.push_back(8'(b));
    rise_cyc = cyc + 1;
    n = 0;
    while (exp_count < 5 && n < 50) begin step(); n++; end
    chk("burst5_captures", 32'(exp_count), 32'd5);
    chk("first_capture_latency", 32'(first_cap_cyc - rise_cyc), 32'd3);
    for (int k = 1; k <= IDLE_TIMEOUT; k++) begin
      step();
      chk("timeout_sloe", 32'(fx2_sloe_n), 32'(k >= IDLE_TIMEOUT));
    end
    chk("burst5_delivered", 32'(delivered), 32'd5);
    chk("burst5_rxcnt", 32'(rx_count), 32'd5);

    // Stall downstream with endless data, then force a capture at full.
    do_reset();
    occ_max = 0;
    delivered = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) fx2_q.push_back(8'($urandom));
    repeat (40) step();
    chk("stall_occ_max_ok", 32'(occ_max >= DEPTH - 2 && occ_max <= DEPTH), 32'd1);
    chk("stall_rxcnt", 32'(rx_count), 32'(DEPTH - 1));
    chk("stall_slrd", 32'(fx2_slrd_n), 32'd1);
    chk("stall_no_ovf", 32'(overflow), 32'd0);
    force dut.slrd_n_r = 1'b0;
    step();
    step();
    release dut.slrd_n_r;
    step();
    step();
    chk("forced_ovf", 32'(overflow), 32'd1);
    chk("forced_rx_gt_depth", 32'(rx_count > 16'(DEPTH)), 32'd1);
    out_ready = 1'b1;
    wait_drained("stall_drain", 400);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // out_ready toggling every cycle over 100 sequential bytes.
    do_reset();
    delivered = 0;
    for (int i = 0; i < 100; i++) fx2_q.push_back(8'(i));
    n = 0;
    while (delivered < 100 && n < 1000) begin
      step();
      out_ready = ~out_ready;
      n++;
    end
    chk("toggle_delivered", 32'(delivered), 32'd100);
    chk("toggle_rxcnt", 32'(rx_count), 32'd100);
    chk("toggle_no_ovf", 32'(overflow), 32'd0);

    // Random endpoint gaps and random downstream backpressure.
    fx2_gaps = 1'b1;
    for (int i = 0; i < 150; i++) fx2_q.push_back(8'($urandom));
    n = 0;
    while ((fx2_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      step();
      out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    fx2_gaps = 1'b0;
    out_ready = 1'b1;
    wait_drained("random_drain", 200);
    chk("random_no_ovf", 32'(overflow), 32'd0);

    // Reset in the middle of a burst.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 30; i++) fx2_q.push_back(8'($urandom));
    n = 0;
    while (exp_q.size() < 6 && n < 50) begin step(); n++; end
    chk("midburst_fill", 32'(exp_q.size() >= 6), 32'd1);
    USB_RESET2 = 1'b1;
    step();
    USB_RESET2 = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_rxcnt", 32'(rx_count), 32'd0);
    chk("midrst_sloe", 32'(fx2_sloe_n), 32'd1);
    chk("midrst_slrd", 32'(fx2_slrd_n), 32'd1);
    delivered = 0;
    out_ready = 1'b1;
    wait_drained("restart_drain", 400);
    chk("restart_rx_matches", 32'(rx_count), 32'(delivered));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
